nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that reuses one 4-bit ripple-carry adder slice to add or subtract WIDTH-bit operands, one nibble per clock.
- Captures a pair of operands through a valid/ready handshake and runs WIDTH/4 slice passes, LSB nibble first, carrying between passes through a registered carry.
- Presents the result through a second valid/ready handshake.
- Sits between an operand source and any result consumer where area matters more than latency.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 28 ++
 rtl/nibble_serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand and result handshake bundle for nibble_serial_adder_ctrl.
// The master side is the operand source and result consumer, and the slave side is the sequencer.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, op_sub, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract built on one 4-bit ripple slice, one nibble per clock, LSB first.
// Carry passes between nibbles through a register, and the result is held until the consumer takes it.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  a_lat_r, b_eff_r, sum_r;
  logic [IDXW-1:0]   idx_r;
  logic              carry_r, cout_r, ovf_r;
  logic              in_ready_r, out_valid_r, busy_r;
  logic              accept_s, last_pass_s;
  logic [IDXW+1:0]   sh_s;
  logic [3:0]        a_nib_s, b_nib_s;
  logic [4:0]        slice_s;

  function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [3:0] s;
    logic       k;
    k = c;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ k;
      k    = (x[i] & y[i]) | (k & (x[i] ^ y[i]));
    end
    return {k, s};
  endfunction

  assign accept_s    = bus.in_valid & in_ready_r;
  assign last_pass_s = (idx_r == IDXW'(NIB - 1));
  assign sh_s        = {idx_r, 2'b00};
  assign a_nib_s     = 4'(a_lat_r >> sh_s);
  assign b_nib_s     = 4'(b_eff_r >> sh_s);
  assign slice_s     = slice_add(a_nib_s, b_nib_s, carry_r);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_pass_s) state_nxt_s = DONE;
        else             state_nxt_s = RUN;
      end
      DONE: begin
        if (out_valid_r & bus.out_ready) state_nxt_s = IDLE;
        else                             state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s == RUN) || (state_nxt_s == DONE);
    end
  end

  // Operand capture and one slice pass per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_lat_r <= '0;
      b_eff_r <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_lat_r <= bus.a;
            b_eff_r <= bus.op_sub ? ~bus.b : bus.b;
            carry_r <= bus.op_sub ? 1'b1 : bus.cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r   <= (sum_r & ~(WIDTH'(4'hF) << sh_s)) | (WIDTH'(slice_s[3:0]) << sh_s);
          carry_r <= slice_s[4];
          idx_r   <= idx_r + IDXW'(1);
          if (last_pass_s) begin
            cout_r <= slice_s[4];
            // Overflow: the operand signs agree but the sign of the result differs from them.
            ovf_r  <= (a_lat_r[WIDTH-1] == b_eff_r[WIDTH-1]) && (slice_s[3] != a_lat_r[WIDTH-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with two instances: WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) b16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  b4 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency is counted in edges including the accept edge: NIB+1.
  task automatic op16(input string tag, input logic sub, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] es, input logic ec, input logic eo);
    int edges;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(b16.in_ready), 32'd1);
    b16.in_valid = 1'b1; b16.op_sub = sub; b16.a = a; b16.b = b; b16.cin = c;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b16.in_valid = 1'b0; b16.op_sub = ~sub; b16.cin = ~c;
    b16.a = 16'($urandom); b16.b = 16'($urandom);
    chk({tag, ".busy"}, {30'd0, b16.in_ready, b16.busy}, 32'd1);
    while (!b16.out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, ".lat"}, 32'(edges), 32'd5);
    chk({tag, ".sum"}, 32'(b16.sum), 32'(es));
    chk({tag, ".cout"}, 32'(b16.cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(b16.ovf), 32'(eo));
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.out_ready = 1'b0;
    chk({tag, ".drop"}, {30'd0, b16.out_valid, b16.in_ready}, 32'd1);
    chk({tag, ".keep"}, 32'(b16.sum), 32'(es));
  endtask

  task automatic op4(input string tag, input logic sub, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [3:0] es, input logic ec);
    int edges;
    @(negedge clk);
    b4.in_valid = 1'b1; b4.op_sub = sub; b4.a = a; b4.b = b; b4.cin = c;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    b4.in_valid = 1'b0; b4.a = 4'($urandom); b4.b = 4'($urandom);
    while (!b4.out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, ".lat"}, 32'(edges), 32'd2);
    chk({tag, ".sum"}, 32'(b4.sum), 32'(es));
    chk({tag, ".cout"}, 32'(b4.cout), 32'(ec));
    b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.out_ready = 1'b0;
    chk({tag, ".drop"}, 32'(b4.out_valid), 32'd0);
  endtask

  initial begin
    int edges;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    b16.in_valid = 1'b0; b16.op_sub = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.out_ready = 1'b0;
    b4.in_valid = 1'b0;  b4.op_sub = 1'b0;  b4.a = '0;  b4.b = '0;  b4.cin = 1'b0;  b4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.flags", {28'd0, b16.in_ready, b16.out_valid, b16.busy, b16.cout}, 32'h8);
    chk("rst.sum", 32'(b16.sum), 32'd0);
    chk("rst.ovf", 32'(b16.ovf), 32'd0);
    rst = 1'b0;

    op16("add1", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    op16("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("posovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("cin", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    op16("sub1", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op16("subovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op16("subeq", 1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("subcin", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: the result must hold and a pending operand must wait for IDLE.
    @(negedge clk);
    b16.in_valid = 1'b1; b16.op_sub = 1'b0; b16.a = 16'h1111; b16.b = 16'h2222; b16.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b16.a = 16'h00FF; b16.b = 16'h0001;
    edges = 1;
    while (!b16.out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("bp.lat", 32'(edges), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold", {b16.out_valid, b16.in_ready, b16.cout, b16.ovf, 12'd0, b16.sum}, 32'h8000_3333);
    end
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.out_ready = 1'b0;
    chk("bp.idle", {30'd0, b16.out_valid, b16.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("bp.acc", 32'(b16.in_ready), 32'd0);
    edges = 1;
    while (!b16.out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("bp.lat2", 32'(edges), 32'd5);
    chk("bp.sum2", 32'(b16.sum), 32'h0100);
    b16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.out_ready = 1'b0;

    // Reset during the 2nd RUN cycle, with a carry already set after the first pass.
    b16.in_valid = 1'b1; b16.op_sub = 1'b0; b16.a = 16'hAAAA; b16.b = 16'h5555; b16.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.flags", {29'd0, b16.in_ready, b16.out_valid, b16.busy}, 32'h4);
    chk("mrst.sum", 32'(b16.sum), 32'd0);
    op16("postrst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    op4("w4add", 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    op4("w4sub", 1'b1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
